// File: rtl/mem_load_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_stage_pkg
// Description : Shared widths, stall encoding, load op codes and the EX->MEM
//               bus layout for the MEM pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_load_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int STALL_WD     = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Codes 6 and 7 are unassigned and decode as a full-word load.
    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic [2:0]  load_op;
        logic        sel_load;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

endpackage
`default_nettype wire

// File: rtl/mem_load_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects the byte/halfword lane of a load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import mem_load_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        // addr[0] is ignored for halfwords: misaligned halfword is undefined.
        w_half = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (load_op)
            LOAD_LB:  data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: data = {24'd0, w_byte};
            LOAD_LH:  data = {{16{w_half[15]}}, w_half};
            LOAD_LHU: data = {16'd0, w_half};
            default:  data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_load_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_stage
// Description : MEM stage: EX->MEM register, load alignment, ID forwarding and
//               SRAM read-word hold across stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_stage
    import mem_load_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    ex_to_mem_t  r_ex_to_mem;
    logic [31:0] r_rdata_hold;
    logic        r_held;

    logic        w_bubble;
    logic        w_advance;
    logic [31:0] w_word;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata;

    assign w_bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);
    assign w_advance = (stall[3] == NO_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_to_mem  <= '0;
            r_rdata_hold <= '0;
            r_held       <= 1'b0;
        end else if (w_bubble) begin
            r_ex_to_mem  <= '0;
            r_held       <= 1'b0;
        end else if (w_advance) begin
            r_ex_to_mem  <= ex_to_mem_bus;
            r_held       <= 1'b0;
        end else if (!r_held) begin
            // The SRAM word is only valid on the first MEM cycle; keep it for the stall.
            r_rdata_hold <= data_sram_rdata;
            r_held       <= 1'b1;
        end
    end

    assign w_word = r_held ? r_rdata_hold : data_sram_rdata;

    load_align u_load_align (
        .load_op (r_ex_to_mem.load_op),
        .addr    (r_ex_to_mem.ex_result[1:0]),
        .word    (w_word),
        .data    (w_load_data)
    );

    assign w_wdata = r_ex_to_mem.sel_load ? w_load_data : r_ex_to_mem.ex_result;

    assign mem_to_wb_bus = {r_ex_to_mem.pc, r_ex_to_mem.rf_we, r_ex_to_mem.rf_waddr, w_wdata};
    assign mem_to_id_bus = {r_ex_to_mem.rf_we, r_ex_to_mem.rf_waddr, w_wdata};

    logic w_unused;
    assign w_unused = ^{r_ex_to_mem.ram_en, r_ex_to_mem.ram_wen, stall[5], stall[2:0]};

endmodule
`default_nettype wire

// File: tb/tb_mem_load_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_load_stage
// Description : Self-checking bench for mem_load_stage with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_load_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] bus;
    logic [31:0] rdata;
    logic [69:0] wb_bus;
    logic [37:0] id_bus;

    int total;
    int bad;
    bit check_en;

    mem_load_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_bus   (id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        return {pc, 1'b0, 4'b0000, op, sel, we, wa, res};
    endfunction

    // Load result from the lane rules, written with shifts and arithmetic.
    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = a[1] ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            3'd1:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Model: the instruction in MEM, how many cycles it has been stuck there,
    // and the SRAM word seen on its first MEM cycle.
    logic [78:0] m_instr;
    int          m_age;
    logic [31:0] m_first_word;

    initial begin
        m_instr      = '0;
        m_age        = 0;
        m_first_word = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_instr = '0;
            m_age   = 0;
        end else if (stall[3] && !stall[4]) begin
            m_instr = '0;
            m_age   = 0;
        end else if (!stall[3]) begin
            m_instr = bus;
            m_age   = 0;
        end else begin
            if (m_age == 0) m_first_word = rdata;
            m_age = m_age + 1;
        end
    end

    function automatic logic [69:0] model_wb();
        logic [31:0] w;
        logic [31:0] wd;
        w  = (m_age == 0) ? rdata : m_first_word;
        wd = m_instr[38] ? load_val(m_instr[41:39], m_instr[1:0], w) : m_instr[31:0];
        return {m_instr[78:47], m_instr[37], m_instr[36:32], wd};
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            logic [69:0] exp_wb;
            exp_wb = model_wb();
            total = total + 1;
            if (wb_bus !== exp_wb) begin
                bad = bad + 1;
                $display("FAIL model_wb: got %h expected %h", wb_bus, exp_wb);
            end
            total = total + 1;
            if (id_bus !== exp_wb[37:0]) begin
                bad = bad + 1;
                $display("FAIL model_id: got %h expected %h", id_bus, exp_wb[37:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] s, input logic [78:0] b,
                       input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst   = r;
        stall = s;
        bus   = b;
        rdata = rd;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    initial begin
        logic [78:0] dc;
        total    = 0;
        bad      = 0;
        check_en = 1'b0;
        rst      = 1'b1;
        stall    = 6'd0;
        bus      = '0;
        rdata    = '0;
        dc       = mk(32'hFFFF_FFF0, 3'd5, 1'b1, 1'b1, 5'd31, 32'h0000_0003);

        cyc(1'b1, 6'd0, '0, 32'h0);
        cyc(1'b1, 6'd0, '0, 32'h0);
        settle();
        chk("reset_wb", wb_bus, 70'd0);
        chk("reset_id", {32'd0, id_bus}, 70'd0);
        check_en = 1'b1;

        // Byte and halfword extraction.
        cyc(1'b0, 6'd0, mk(32'h100, 3'd1, 1'b1, 1'b1, 5'd8, 32'h0000_1001), 32'h0);
        cyc(1'b0, 6'd0, mk(32'h104, 3'd2, 1'b1, 1'b1, 5'd8, 32'h0000_1001), 32'h1234_80FF);
        settle();
        chk("lb_sign", {32'd0, id_bus}, {32'd0, 1'b1, 5'd8, 32'hFFFF_FF80});
        chk("lb_pc", {38'd0, wb_bus[69:38]}, {38'd0, 32'h100});
        cyc(1'b0, 6'd0, mk(32'h108, 3'd3, 1'b1, 1'b1, 5'd9, 32'h0000_2002), 32'h1234_80FF);
        settle();
        chk("lbu_zero", {32'd0, id_bus}, {32'd0, 1'b1, 5'd8, 32'h0000_0080});
        cyc(1'b0, 6'd0, mk(32'h10C, 3'd4, 1'b1, 1'b1, 5'd9, 32'h0000_3000), 32'h1234_80FF);
        settle();
        chk("lh_hi", {32'd0, id_bus}, {32'd0, 1'b1, 5'd9, 32'h0000_1234});
        cyc(1'b0, 6'd0, mk(32'h110, 3'd3, 1'b1, 1'b1, 5'd9, 32'h0000_3000), 32'h0000_8001);
        settle();
        chk("lhu_lo", {32'd0, id_bus}, {32'd0, 1'b1, 5'd9, 32'h0000_8001});
        cyc(1'b0, 6'd0, mk(32'h114, 3'd0, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF), 32'h0000_8001);
        settle();
        chk("lh_sign", {32'd0, id_bus}, {32'd0, 1'b1, 5'd9, 32'hFFFF_8001});

        // Non-load pass-through, then a stalled LW keeps its first word.
        cyc(1'b0, 6'd0, mk(32'h118, 3'd5, 1'b1, 1'b1, 5'd10, 32'h0000_4000), 32'h1111_1111);
        settle();
        chk("alu_wb", wb_bus, {32'h114, 1'b1, 5'd3, 32'hDEAD_BEEF});
        chk("alu_id", {32'd0, id_bus}, {32'd0, 1'b1, 5'd3, 32'hDEAD_BEEF});
        cyc(1'b0, HOLD, dc, 32'hCAFE_0001);
        settle();
        chk("lw_first", {32'd0, id_bus}, {32'd0, 1'b1, 5'd10, 32'hCAFE_0001});
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, HOLD, dc, 32'h0BAD_0BAD);
            settle();
            chk("lw_hold", {32'd0, id_bus}, {32'd0, 1'b1, 5'd10, 32'hCAFE_0001});
        end
        cyc(1'b0, BUBBLE, dc, 32'h0BAD_0BAD);
        settle();
        chk("lw_hold_pre_bubble", {32'd0, id_bus}, {32'd0, 1'b1, 5'd10, 32'hCAFE_0001});
        cyc(1'b0, 6'd0, mk(32'h120, 3'd0, 1'b0, 1'b1, 5'd4, 32'h5555_AAAA), 32'h0BAD_0BAD);
        settle();
        chk("bubble_wb", wb_bus, 70'd0);
        chk("bubble_id", {32'd0, id_bus}, 70'd0);
        cyc(1'b0, 6'd0, mk(32'h124, 3'd5, 1'b1, 1'b1, 5'd5, 32'h0000_5000), 32'h1212_1212);
        settle();
        chk("after_bubble", wb_bus, {32'h120, 1'b1, 5'd4, 32'h5555_AAAA});
        cyc(1'b0, 6'd0, mk(32'h128, 3'd5, 1'b1, 1'b1, 5'd6, 32'h0000_6000), 32'h7654_3210);
        settle();
        chk("lw_live_after_bubble", {32'd0, id_bus}, {32'd0, 1'b1, 5'd5, 32'h7654_3210});

        // Reset in the middle of a stall.
        cyc(1'b0, HOLD, dc, 32'hCAFE_0001);
        settle();
        chk("lw2_first", {32'd0, id_bus}, {32'd0, 1'b1, 5'd6, 32'hCAFE_0001});
        cyc(1'b0, HOLD, dc, 32'h0BAD_0BAD);
        settle();
        chk("lw2_hold", {32'd0, id_bus}, {32'd0, 1'b1, 5'd6, 32'hCAFE_0001});
        cyc(1'b1, HOLD, dc, 32'h0BAD_0BAD);
        cyc(1'b0, 6'd0, mk(32'h130, 3'd5, 1'b1, 1'b1, 5'd7, 32'h0000_7000), 32'h0BAD_0BAD);
        settle();
        chk("rst_mid_stall_wb", wb_bus, 70'd0);
        chk("rst_mid_stall_id", {32'd0, id_bus}, 70'd0);
        cyc(1'b0, 6'd0, mk(32'h134, 3'd0, 1'b0, 1'b0, 5'd0, 32'h0), 32'h1357_2468);
        settle();
        chk("lw_live_after_rst", {32'd0, id_bus}, {32'd0, 1'b1, 5'd7, 32'h1357_2468});

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            logic [5:0]  s;
            logic [2:0]  op;
            logic        sel;
            int          pick;
            pick = $urandom_range(0, 99);
            if (pick < 55)      s = 6'd0;
            else if (pick < 78) s = HOLD;
            else if (pick < 88) s = BUBBLE;
            else                s = 6'($urandom);
            op  = 3'($urandom_range(0, 7));
            sel = (op == 3'd0) ? 1'b0 : 1'($urandom);
            cyc(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, s,
                {$urandom(), 1'($urandom), 4'($urandom), op, sel, 1'($urandom),
                 5'($urandom), $urandom()},
                $urandom());
        end
        settle();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
